ex_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M/RV64M execute unit sitting beside the single-cycle ALU in the EX stage.

---
 rtl/ex_muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit: MUL* in MUL_LAT cycles, DIV/REM in XLEN+1
// (or 1 for divide-by-zero / signed overflow when EARLY_OUT=1); stalls the pipe while busy.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 3,
  parameter int EARLY_OUT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       rs2,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  stall_req
);

  localparam int CNT_W = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [XLEN-1:0]         r_result;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [XLEN-1:0]         r_rem, r_quo, r_dvs;
  logic                    r_qneg, r_rneg, r_is_rem, r_special;

  logic                    w_accept, w_sgn, w_neg1, w_neg2, w_div0, w_ovf, w_special, w_early;
  logic [XLEN-1:0]         w_abs1, w_abs2, w_special_res, w_mul_res;
  logic [2*XLEN-1:0]       w_mul_a, w_mul_b, w_prod;
  logic [XLEN:0]           w_diff;
  logic                    w_qbit;
  logic [XLEN-1:0]         w_rem_nxt, w_quo_nxt, w_quo_fix, w_rem_fix, w_div_res;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign stall_req = (r_state != S_IDLE) && !(out_valid && out_ready);
  assign rd_data_o = r_result;
  assign rd_o      = r_rd;

  // flush wins over accept: an op offered during a flush cycle is dropped
  assign w_accept = in_valid && in_ready && !flush;

  assign w_sgn         = !op[0];
  assign w_neg1        = w_sgn && rs1[XLEN-1];
  assign w_neg2        = w_sgn && rs2[XLEN-1];
  assign w_abs1        = w_neg1 ? -rs1 : rs1;
  assign w_abs2        = w_neg2 ? -rs2 : rs2;
  assign w_div0        = (rs2 == '0);
  assign w_ovf         = w_sgn && (rs1 == MIN_INT) && (rs2 == '1);
  assign w_special     = w_div0 || w_ovf;
  assign w_special_res = op[1] ? (w_div0 ? rs1 : '0) : (w_div0 ? '1 : rs1);
  assign w_early       = (EARLY_OUT != 0) && op[2] && w_special;

  // sign-extend per operand so one 2*XLEN product covers all four multiply flavours
  assign w_mul_a   = {{XLEN{(op[1] ^ op[0]) & rs1[XLEN-1]}}, rs1};
  assign w_mul_b   = {{XLEN{(op[1:0] == 2'b01) & rs2[XLEN-1]}}, rs2};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = (op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // restoring step: dividend bits shift out of r_quo into r_rem as quotient bits shift in
  assign w_diff    = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
  assign w_qbit    = !w_diff[XLEN];
  assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
  assign w_quo_fix = r_qneg ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_rneg ? -w_rem_nxt : w_rem_nxt;
  // corner-case value was parked in r_result at accept when the full-latency path runs
  assign w_div_res = r_special ? r_result : (r_is_rem ? w_rem_fix : w_quo_fix);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!op[2])       w_state_nxt = (MUL_LAT <= 1) ? S_DONE : S_MUL;
          else if (w_early) w_state_nxt = S_DONE;
          else              w_state_nxt = S_DIV;
        end
      end
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DIV:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_is_rem  <= 1'b0;
      r_special <= 1'b0;
    end else if (w_accept) begin
      r_rd      <= rd_i;
      r_qneg    <= w_neg1 ^ w_neg2;
      r_rneg    <= w_neg1;
      r_is_rem  <= op[1];
      r_special <= w_special;
      r_rem     <= '0;
      r_quo     <= w_abs1;
      r_dvs     <= w_abs2;
      if (!op[2]) begin
        r_result <= w_mul_res;
        r_cnt    <= MUL_CNT;
      end else begin
        r_result <= w_special_res;
        r_cnt    <= DIV_CNT;
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) r_result <= w_div_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32, MUL_LAT=3, EARLY_OUT=1): directed corner
// cases followed by random ops compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, stall_req;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, rd_data_o;
  logic [4:0]  rd_i, rd_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .REG_ADDR_W(5), .MUL_LAT(3), .EARLY_OUT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd_i(rd_i), .out_valid(out_valid),
    .out_ready(out_ready), .rd_data_o(rd_data_o), .rd_o(rd_o), .stall_req(stall_req)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RISC-V M-extension results from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 4) return 3;
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, wait for the result, hold it 'hold' cycles with out_ready low, then drain it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_val,
                        input int exp_lat, input int hold);
    int cyc;
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; rd_i = rd;
    tick();
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_i = 5'($urandom);
    cyc = 1;
    if (!out_valid) chk({tag, " busy_stall"}, {in_ready, stall_req}, 2'b01);
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, " out_valid"}, out_valid, 1'b1);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " rd_data"}, rd_data_o, exp_val);
    chk({tag, " rd"}, rd_o, rd);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, " hold"}, {out_valid, in_ready, stall_req, rd_data_o, rd_o},
          {1'b1, 1'b0, 1'b1, exp_val, rd});
    end
    out_ready = 1'b1;
    #1;
    chk({tag, " stall_release"}, stall_req, 1'b0);
    tick();
    out_ready = 1'b0;
    chk({tag, " back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int cnt;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [31:0] pat [5];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd_i = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset", {out_valid, in_ready, stall_req, rd_data_o, rd_o}, {1'b0, 1'b1, 1'b0, 32'd0, 5'd0});
    tick();

    run_op("mul",    3'd0, 32'hFFFF_FFFF, 32'd2, 5'd1, 32'hFFFF_FFFE, 3, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd2, 5'd2, 32'h0000_0001, 3, 0);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 3, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 3, 1);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 0);
    run_op("divu0",  3'd5, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, 1, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1, 0);
    run_op("rem0",   3'd6, 32'hFFFF_FFF0, 32'd0, 5'd10, 32'hFFFF_FFF0, 1, 0);
    run_op("divuhold", 3'd5, 32'd10, 32'd3, 5'd11, 32'd3, 33, 5);

    // flush part-way through a divide; the result must never appear
    in_valid = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd_i = 5'd12;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush idle", {out_valid, in_ready, stall_req}, 3'b010);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd13, 32'd12, 3, 0);
    cnt = 0;
    repeat (40) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("flush no stray result", cnt, 0);

    // op offered together with flush is dropped
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6; rd_i = 5'd14;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush+valid not taken", {in_ready, stall_req}, 2'b10);
    cnt = 0;
    repeat (5) begin
      tick();
      if (out_valid || !in_ready) cnt++;
    end
    chk("flush+valid stays idle", cnt, 0);

    // flush also kills a result that is waiting for out_ready
    in_valid = 1'b1; op = 3'd0; rs1 = 32'd2; rs2 = 32'd9; rd_i = 5'd15;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("pre-flush done", out_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in done", {out_valid, in_ready}, 2'b01);

    // synchronous reset during a multiply
    in_valid = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd7; rd_i = 5'd16;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid-op", {out_valid, in_ready, stall_req, rd_data_o, rd_o},
        {1'b0, 1'b1, 1'b0, 32'd0, 5'd0});
    tick();

    pat[0] = 32'd0; pat[1] = 32'hFFFF_FFFF; pat[2] = 32'h8000_0000;
    pat[3] = 32'h7FFF_FFFF; pat[4] = 32'd1;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? pat[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pat[$urandom_range(0, 4)] :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op($sformatf("rand%0d op%0d", i, o), o, a, b, 5'($urandom), ref_res(o, a, b),
             ref_lat(o, a, b), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
